// File: rtl/clk_freq_monitor.sv
// Frequency-window qualifier for the ADC clock counter: lock/loss hysteresis,
// IIR-smoothed frequency estimate, sticky loss/timeout flags and a strobe watchdog.
module clk_freq_monitor #(
  parameter logic [31:0] LOW_LIMIT      = 32'd79_000_000,
  parameter logic [31:0] HIGH_LIMIT     = 32'd81_000_000,
  parameter int unsigned LOCK_COUNT     = 4,
  parameter int unsigned LOSS_COUNT     = 3,
  parameter int unsigned AVG_SHIFT      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 250_000
) (
  input  logic        I_ref_clk,
  input  logic        reset,
  input  logic [31:0] I_freq_word,
  input  logic        I_freq_set,
  input  logic        I_clear_sticky,
  output logic [1:0]  O_state,
  output logic        O_locked,
  output logic        O_avg_valid,
  output logic [31:0] O_freq_avg,
  output logic [31:0] O_last_freq,
  output logic        O_in_range,
  output logic        O_lost,
  output logic        O_timeout,
  output logic        O_loss_pulse
);

  // state    | meaning
  // SEARCH   | no lock, waiting for a first in-range sample
  // ACQUIRE  | counting consecutive in-range samples toward lock
  // LOCKED   | locked, last sample in range
  // DEGRADED | locked, counting consecutive out-of-range samples toward loss
  typedef enum logic [1:0] {
    ST_SEARCH   = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_DEGRADED = 2'd3
  } state_t;

  localparam int WD_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WD_W   = (WD_RAW < 18) ? 18 : WD_RAW;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  state_t            state_q, state_d;
  logic              set_dly_q, set_dly_d;
  logic [3:0]        good_cnt_q, good_cnt_d;
  logic [3:0]        bad_cnt_q, bad_cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [31:0]       avg_q, avg_d;
  logic [31:0]       last_freq_q, last_freq_d;
  logic              in_range_q, in_range_d;
  logic              lost_q, lost_d;
  logic              timeout_q, timeout_d;
  logic              loss_pulse_q, loss_pulse_d;
  logic              locked_q, locked_d;

  logic              sample_evt;
  logic              word_in_range;
  logic              wd_expire;
  logic              loss_evt;
  logic              timeout_set;
  logic signed [32:0] diff;
  logic signed [32:0] step;
  logic [31:0]       avg_upd;

  assign sample_evt    = I_freq_set & ~set_dly_q;
  assign word_in_range = (I_freq_word >= LOW_LIMIT) && (I_freq_word <= HIGH_LIMIT);
  assign set_dly_d     = I_freq_set;

  // Floor-rounded IIR step; the new average always lands between old avg and word.
  assign diff    = $signed({1'b0, I_freq_word}) - $signed({1'b0, avg_q});
  assign step    = diff >>> AVG_SHIFT;
  assign avg_upd = avg_q + 32'(step);

  always_comb begin
    wd_d      = wd_q;
    wd_expire = 1'b0;
    if (sample_evt) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d      = wd_q + 1'b1;
      wd_expire = (wd_q == WD_MAX - 1'b1);
    end
  end

  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    avg_d       = avg_q;
    last_freq_d = last_freq_q;
    in_range_d  = in_range_q;
    loss_evt    = 1'b0;
    timeout_set = 1'b0;

    if (sample_evt) begin
      last_freq_d = I_freq_word;
      in_range_d  = word_in_range;
      case (state_q)
        ST_SEARCH: begin
          if (word_in_range) begin
            avg_d      = I_freq_word;
            good_cnt_d = 4'd1;
            state_d    = (LOCK_N == 4'd1) ? ST_LOCKED : ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (word_in_range) begin
            good_cnt_d = good_cnt_q + 4'd1;
            avg_d      = avg_upd;
            if (good_cnt_q + 4'd1 == LOCK_N) state_d = ST_LOCKED;
          end else begin
            good_cnt_d = 4'd0;
            state_d    = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (word_in_range) begin
            avg_d     = avg_upd;
            bad_cnt_d = 4'd0;
          end else if (LOSS_N == 4'd1) begin
            loss_evt = 1'b1;
          end else begin
            bad_cnt_d = 4'd1;
            state_d   = ST_DEGRADED;
          end
        end
        ST_DEGRADED: begin
          if (word_in_range) begin
            avg_d     = avg_upd;
            bad_cnt_d = 4'd0;
            state_d   = ST_LOCKED;
          end else if (bad_cnt_q + 4'd1 == LOSS_N) begin
            loss_evt = 1'b1;
          end else begin
            bad_cnt_d = bad_cnt_q + 4'd1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end else if (wd_expire) begin
      timeout_set = 1'b1;
      loss_evt    = (state_q == ST_LOCKED) || (state_q == ST_DEGRADED);
      state_d     = ST_SEARCH;
      good_cnt_d  = 4'd0;
      bad_cnt_d   = 4'd0;
    end

    if (loss_evt) begin
      state_d    = ST_SEARCH;
      good_cnt_d = 4'd0;
      bad_cnt_d  = 4'd0;
    end
  end

  // Sticky flags: a set on the same edge as a clear takes priority.
  assign lost_d       = (lost_q & ~I_clear_sticky) | loss_evt;
  assign timeout_d    = (timeout_q & ~I_clear_sticky) | timeout_set;
  assign loss_pulse_d = loss_evt;
  assign locked_d     = (state_d == ST_LOCKED) || (state_d == ST_DEGRADED);

  always_ff @(posedge I_ref_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_SEARCH;
      set_dly_q    <= 1'b0;
      good_cnt_q   <= 4'd0;
      bad_cnt_q    <= 4'd0;
      wd_q         <= '0;
      avg_q        <= 32'd0;
      last_freq_q  <= 32'd0;
      in_range_q   <= 1'b0;
      lost_q       <= 1'b0;
      timeout_q    <= 1'b0;
      loss_pulse_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      set_dly_q    <= set_dly_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      wd_q         <= wd_d;
      avg_q        <= avg_d;
      last_freq_q  <= last_freq_d;
      in_range_q   <= in_range_d;
      lost_q       <= lost_d;
      timeout_q    <= timeout_d;
      loss_pulse_q <= loss_pulse_d;
      locked_q     <= locked_d;
    end
  end

  assign O_state      = state_q;
  assign O_locked     = locked_q;
  assign O_avg_valid  = locked_q;
  assign O_freq_avg   = avg_q;
  assign O_last_freq  = last_freq_q;
  assign O_in_range   = in_range_q;
  assign O_lost       = lost_q;
  assign O_timeout    = timeout_q;
  assign O_loss_pulse = loss_pulse_q;

endmodule
